// File: rtl/ahb_arbiter_2m.sv
// Two-master AHB-Lite arbiter: round-robin grant with a hold limit, stalled masters buffered.
// Latency: granted idle master passes through combinationally; a buffered master issues >=1 cycle later.
// Backpressure: the non-granted master is held via its hready (buffered, never dropped); downstream hready freezes grant.
//
// Ports:
//   hclk, hreset               clock, synchronous active-high reset
//   m0_* / m1_*                master-side AHB-Lite address/control/write data in; hrdata/hready/hresp out
//   haddr/htrans/hwrite/hsize  downstream address phase
//   hwdata                     write data of the current data-phase owner
//   hrdata/hready/hresp        downstream response (hrdata broadcast to both masters)
module ahb_arbiter_2m #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic [AW-1:0] m0_haddr,
    input  logic [1:0]    m0_htrans,
    input  logic          m0_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [DW-1:0] m0_hwdata,
    output logic [DW-1:0] m0_hrdata,
    output logic          m0_hready,
    output logic          m0_hresp,
    input  logic [AW-1:0] m1_haddr,
    input  logic [1:0]    m1_htrans,
    input  logic          m1_hwrite,
    input  logic [2:0]    m1_hsize,
    input  logic [DW-1:0] m1_hwdata,
    output logic [DW-1:0] m1_hrdata,
    output logic          m1_hready,
    output logic          m1_hresp,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [DW-1:0] hwdata,
    input  logic [DW-1:0] hrdata,
    input  logic          hready,
    input  logic          hresp
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam int              HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);

    // Per-master views of the live bus so the rest can index by master number.
    logic [AW-1:0] m_addr  [2];
    logic [1:0]    m_trans [2];
    logic          m_write [2];
    logic [2:0]    m_size  [2];
    logic [DW-1:0] m_wdata [2];

    assign m_addr[0]  = m0_haddr;
    assign m_addr[1]  = m1_haddr;
    assign m_trans[0] = m0_htrans;
    assign m_trans[1] = m1_htrans;
    assign m_write[0] = m0_hwrite;
    assign m_write[1] = m1_hwrite;
    assign m_size[0]  = m0_hsize;
    assign m_size[1]  = m1_hsize;
    assign m_wdata[0] = m0_hwdata;
    assign m_wdata[1] = m1_hwdata;

    // Arbitration state
    logic          sel;
    logic [1:0]    pend;
    logic          dph_v;
    logic          dph;
    logic [HW-1:0] hold;
    logic          first;

    // Buffered address phases
    logic [AW-1:0] cap_addr  [2];
    logic          cap_write [2];
    logic [2:0]    cap_size  [2];

    logic [1:0]    mready;
    logic [1:0]    capture;
    logic [1:0]    pend_n;
    logic          issue;
    logic          issue_live;
    logic          other;
    logic          other_req;
    logic          switch_grant;
    logic [HW-1:0] hold_inc;
    logic [1:0]    live_trans;

    // Downstream address phase: buffered phase of the owner takes precedence over its live bus.
    always_comb begin
        live_trans = m_trans[sel];
        // A SEQ cannot follow another master's transfer; BUSY carries no transfer downstream.
        if (live_trans == TR_SEQ && first) begin
            live_trans = TR_NONSEQ;
        end else if (live_trans == TR_BUSY) begin
            live_trans = TR_IDLE;
        end
        haddr  = m_addr[sel];
        hwrite = m_write[sel];
        hsize  = m_size[sel];
        htrans = live_trans;
        if (pend[sel]) begin
            haddr  = cap_addr[sel];
            hwrite = cap_write[sel];
            hsize  = cap_size[sel];
            htrans = TR_NONSEQ;
        end
        if (hreset) begin
            htrans = TR_IDLE;
        end
    end

    assign issue      = hready & htrans[1];
    assign issue_live = issue & ~pend[sel];

    // Master-side ready/response
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            mready[i] = 1'b1;
            if (!hreset) begin
                if (pend[i]) begin
                    mready[i] = 1'b0;
                end else if (dph_v && (dph == 1'(i))) begin
                    mready[i] = hready;
                end
            end
        end
    end

    assign m0_hready = mready[0];
    assign m1_hready = mready[1];
    assign m0_hresp  = !hreset && dph_v && (dph == 1'b0) && hresp;
    assign m1_hresp  = !hreset && dph_v && (dph == 1'b1) && hresp;
    assign m0_hrdata = hrdata;
    assign m1_hrdata = hrdata;
    assign hwdata    = dph_v ? m_wdata[dph] : '0;

    // Capture any accepted address phase that did not go straight downstream.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            capture[i] = m_trans[i][1] & mready[i] & ~pend[i]
                       & ~((sel == 1'(i)) & issue_live);
            pend_n[i]  = pend[i];
            if (capture[i]) begin
                pend_n[i] = 1'b1;
            end else if (issue && pend[i] && (sel == 1'(i))) begin
                pend_n[i] = 1'b0;
            end
        end
    end

    assign hold_inc     = (hold == HOLD_MAX) ? hold : hold + 1'b1;
    assign other        = ~sel;
    assign other_req    = pend_n[other] | m_trans[other][1];
    // Hand over when the owner went idle or just used up its hold allowance.
    assign switch_grant = hready & other_req & (~issue | (hold_inc == HOLD_MAX));

    always_ff @(posedge hclk) begin
        if (hreset) begin
            sel   <= 1'b0;
            pend  <= 2'b00;
            dph_v <= 1'b0;
            dph   <= 1'b0;
            hold  <= '0;
            first <= 1'b0;
        end else begin
            pend <= pend_n;
            if (hready) begin
                dph_v <= issue;
                if (issue) begin
                    dph <= sel;
                end
                if (switch_grant) begin
                    sel   <= other;
                    hold  <= '0;
                    first <= 1'b1;
                end else if (issue) begin
                    hold  <= hold_inc;
                    first <= 1'b0;
                end
            end
        end
    end

    // Buffer contents are qualified by pend, so they need no reset.
    always_ff @(posedge hclk) begin
        for (int i = 0; i < 2; i++) begin
            if (!hreset && capture[i]) begin
                cap_addr[i]  <= m_addr[i];
                cap_write[i] <= m_write[i];
                cap_size[i]  <= m_size[i];
            end
        end
    end

endmodule
